sram_wr_port: RTL and testbench
===============================

SRAM_WR_PORT -- requirements
Module: sram_wr_port

Interface
REQ-001 The block SHALL take parameter FIFO_DEPTH, default 4, which sets the number of write-buffer entries (power of two, 2..16).
REQ-002 The block SHALL provide port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL provide port ARESET, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL provide port wen, input, 1 bit: the per-cycle write request from the AXI write channel; each cycle it is high is one write beat.
REQ-005 The block SHALL provide port awsize, input, 3 bits: the beat size; 0 = byte, 1 = halfword, 2 = word, and 3..7 are treated as word.
REQ-006 The block SHALL provide port awaddr, input, 16 bits: the byte address of the beat.
REQ-007 The block SHALL provide port wdata, input, 32 bits: the beat data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-008 The block SHALL provide port sram_req, output, 1 bit: a buffered write is pending at the head of the FIFO.
REQ-009 The block SHALL provide port sram_gnt, input, 1 bit: the SRAM arbiter accepts the head write this cycle.
REQ-010 The block SHALL provide port sram_addr, output, 14 bits: the word address of the head write.
REQ-011 The block SHALL provide port sram_be, output, 4 bits: the byte enables of the head write.
REQ-012 The block SHALL provide port sram_wdata, output, 32 bits: the lane-aligned data of the head write.
REQ-013 The block SHALL provide port fill, output, 5 bits: the current number of FIFO entries.
REQ-014 The block SHALL provide port ovf_err, output, 1 bit: sticky flag, set when a beat is dropped because the FIFO is full.
REQ-015 The block SHALL provide port align_err, output, 1 bit: sticky flag, set when a beat is dropped because it is misaligned.

Function
REQ-016 The word address SHALL equal awaddr[15:2], and the byte lane SHALL equal awaddr[1:0].
REQ-017 For a byte beat, sram_be SHALL be 1 shifted left by the lane, and the data SHALL be wdata[7:0] replicated to all four lanes.
REQ-018 For a halfword beat, sram_be SHALL be 4'b0011 when awaddr[1]=0 and 4'b1100 otherwise, and the data SHALL be {wdata[15:0], wdata[15:0]}.
REQ-019 For a word beat, sram_be SHALL be 4'b1111 and the data SHALL be wdata unchanged.
REQ-020 A beat is misaligned when it is a halfword with awaddr[0]=1, or a word with awaddr[1:0]≠0; a misaligned beat SHALL NOT be pushed, and align_err SHALL set at the next edge.
REQ-021 A push SHALL occur when wen=1, the beat is aligned, and the FIFO is not full or a pop happens in the same cycle.
REQ-022 A pop SHALL occur when sram_req=1 and sram_gnt=1; the SRAM write of the head entry completes on that edge.
REQ-023 sram_req SHALL be driven from registered state only, and SHALL equal (fill≠0).
REQ-024 sram_addr, sram_be and sram_wdata SHALL come from the head entry storage, with no combinational path from wen, awaddr or wdata.
REQ-025 When the FIFO is empty, sram_addr, sram_be and sram_wdata SHALL be 0.
REQ-026 Latency: a beat presented in cycle k SHALL appear at the head in cycle k+1 at the earliest, when the FIFO was empty or the pop in cycle k emptied it.
REQ-027 Order SHALL be strict FIFO, and sram_gnt SHALL be ignored while sram_req=0.
REQ-028 On simultaneous push and pop, fill SHALL stay unchanged; this SHALL hold both when the FIFO is full and when it holds one entry.
REQ-029 A beat arriving while full with no pop SHALL be dropped, ovf_err SHALL set at the next edge, and the existing contents SHALL be unchanged.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
REQ-031 fill SHALL range over 0..FIFO_DEPTH and SHALL never exceed FIFO_DEPTH or underflow.
REQ-032 ovf_err and align_err SHALL remain set until reset, and SHALL have no other clear path.

Reset
REQ-033 With ARESET=1 at an edge, the pointers, fill, ovf_err and align_err SHALL be 0, and therefore sram_req=0 and the sram_addr/sram_be/sram_wdata outputs SHALL be 0.
REQ-034 Reset SHALL take priority over a simultaneous push or pop.
REQ-035 Entries pending at reset SHALL be discarded.
REQ-036 Entry storage SHALL need no reset.

Verification
REQ-037 Reset and word write: release reset, then wen=1, awsize=2, awaddr=0x0010, wdata=0xDEADBEEF for one cycle -> the next cycle shows sram_req=1, sram_addr=0x0004, sram_be=4'hF, sram_wdata=0xDEADBEEF; sram_gnt=1 -> fill=0.
REQ-038 Byte and halfword lanes: a byte to 0x0003 with data 0x5A -> be=4'b1000, wdata=0x5A5A5A5A; a halfword to 0x0006 with data 0x1234 -> be=4'b1100, wdata=0x12341234.
REQ-039 Misalignment: a halfword to 0x0001, or a word to 0x0002 -> no push, fill unchanged, align_err=1 and it stays 1.
REQ-040 Full/overflow with FIFO_DEPTH=4 and sram_gnt=0: five consecutive beats -> fill=4, ovf_err=1, and the first four beats later drain in order once sram_gnt=1.
REQ-041 Simultaneous push/pop while full, with sram_gnt=1 and wen=1 -> fill stays 4, no ovf_err, and the new beat is accepted.
REQ-042 Mid-operation reset: assert ARESET with fill=3 -> the next cycle has fill=0, sram_req=0, and both error flags cleared.

Source files
------------

// File: rtl/sram_wr_port.sv
// sram_wr_port: AXI write beats lane-aligned and buffered in a small FIFO toward an SRAM arbiter.
module sram_wr_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        wen,
  input  logic [2:0]  awsize,
  input  logic [15:0] awaddr,
  input  logic [31:0] wdata,
  output logic        sram_req,
  input  logic        sram_gnt,
  output logic [13:0] sram_addr,
  output logic [3:0]  sram_be,
  output logic [31:0] sram_wdata,
  output logic [4:0]  fill,
  output logic        ovf_err,
  output logic        align_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW-1:0] wptr, rptr;
  logic [13:0] addr_mem [FIFO_DEPTH];
  logic [3:0]  be_mem   [FIFO_DEPTH];
  logic [31:0] data_mem [FIFO_DEPTH];
  logic is_word, is_half, misalign, full, pop, push;
  logic [3:0]  be;
  logic [31:0] data;
  always_comb begin
    is_word  = awsize >= 3'd2;
    is_half  = awsize == 3'd1;
    misalign = (is_half & awaddr[0]) | (is_word & |awaddr[1:0]);
    be       = is_word ? 4'hF : is_half ? (awaddr[1] ? 4'hC : 4'h3) : 4'b0001 << awaddr[1:0];
    data     = is_word ? wdata : is_half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    full     = fill == 5'(FIFO_DEPTH);
    pop      = sram_req & sram_gnt;
    push     = wen & ~misalign & (~full | pop);
  end
  // head outputs come only from stored entries, forced to zero when empty
  always_comb begin
    sram_req   = fill != 5'd0;
    sram_addr  = sram_req ? addr_mem[rptr] : '0;
    sram_be    = sram_req ? be_mem[rptr]   : '0;
    sram_wdata = sram_req ? data_mem[rptr] : '0;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wptr      <= '0;
      rptr      <= '0;
      fill      <= '0;
      ovf_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      wptr      <= push ? wptr + AW'(1) : wptr;
      rptr      <= pop ? rptr + AW'(1) : rptr;
      fill      <= fill + 5'(push) - 5'(pop);
      ovf_err   <= ovf_err | (wen & ~misalign & full & ~pop);
      align_err <= align_err | (wen & misalign);
    end
  end
  always_ff @(posedge ACLK) begin
    if (push) begin
      addr_mem[wptr] <= awaddr[15:2];
      be_mem[wptr]   <= be;
      data_mem[wptr] <= data;
    end
  end
endmodule

// File: tb/tb_sram_wr_port.sv
// tb_sram_wr_port: vector table, directed corner sequences and random traffic against a queue model.
module tb_sram_wr_port;
  localparam int DEPTH = 4;
  logic        ACLK = 1'b0, ARESET = 1'b1, wen = 1'b0, sram_gnt = 1'b0;
  logic [2:0]  awsize = '0;
  logic [15:0] awaddr = '0;
  logic [31:0] wdata = '0;
  logic        sram_req, ovf_err, align_err;
  logic [13:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata;
  logic [4:0]  fill;
  int errors = 0, checks = 0;

  sram_wr_port #(.FIFO_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .wen(wen), .awsize(awsize), .awaddr(awaddr),
    .wdata(wdata), .sram_req(sram_req), .sram_gnt(sram_gnt), .sram_addr(sram_addr),
    .sram_be(sram_be), .sram_wdata(sram_wdata), .fill(fill), .ovf_err(ovf_err),
    .align_err(align_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  bit m_ovf, m_al;

  function automatic void model(input logic r, w, input logic [2:0] s,
                                input logic [15:0] a, input logic [31:0] d, input logic g);
    bit word, half, mis, pop, push;
    int lane;
    ent_t e;
    if (r) begin
      q.delete();
      m_ovf = 0;
      m_al = 0;
      return;
    end
    word = s >= 2;
    half = s == 1;
    lane = int'(a) % 4;
    mis = (half && lane % 2 == 1) || (word && lane != 0);
    pop = q.size() != 0 && g;
    push = 0;
    if (w && mis) m_al = 1;
    else if (w) begin
      if (q.size() < DEPTH || pop) push = 1;
      else m_ovf = 1;
    end
    e.a = 14'(int'(a) / 4);
    e.be = word ? 4'hF : half ? (lane >= 2 ? 4'hC : 4'h3) : 4'(1 << lane);
    e.d = word ? d : half ? 32'(d[15:0]) * 32'h0001_0001 : 32'(d[7:0]) * 32'h0101_0101;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc(input logic r, w, input logic [2:0] s, input logic [15:0] a,
                     input logic [31:0] d, input logic g);
    ARESET = r; wen = w; awsize = s; awaddr = a; wdata = d; sram_gnt = g;
    model(r, w, s, a, d, g);
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_model(input string n);
    ent_t h;
    h = q.size() != 0 ? q[0] : '0;
    chk({n, ".req"}, 32'(sram_req), 32'(q.size() != 0));
    chk({n, ".addr"}, 32'(sram_addr), 32'(h.a));
    chk({n, ".be"}, 32'(sram_be), 32'(h.be));
    chk({n, ".wdata"}, sram_wdata, h.d);
    chk({n, ".fill"}, 32'(fill), 32'(q.size()));
    chk({n, ".ovf"}, 32'(ovf_err), 32'(m_ovf));
    chk({n, ".align"}, 32'(align_err), 32'(m_al));
  endtask

  typedef struct {
    logic w; logic [2:0] s; logic [15:0] a; logic [31:0] d; logic g;
    logic req; logic [13:0] addr; logic [3:0] be; logic [31:0] wd; logic [4:0] f;
    logic ovf; logic al;
  } vec_t;
  vec_t vt[7];

  initial begin
    vt[0] = '{1, 2, 16'h0010, 32'hDEADBEEF, 0, 1, 14'h0004, 4'hF, 32'hDEADBEEF, 1, 0, 0};
    vt[1] = '{0, 0, 16'h0000, 32'h0, 1, 0, 14'h0, 4'h0, 32'h0, 0, 0, 0};
    vt[2] = '{1, 0, 16'h0003, 32'h5A, 0, 1, 14'h0, 4'h8, 32'h5A5A5A5A, 1, 0, 0};
    vt[3] = '{1, 1, 16'h0006, 32'h1234, 1, 1, 14'h1, 4'hC, 32'h12341234, 1, 0, 0};
    vt[4] = '{1, 1, 16'h0001, 32'hFFFF, 0, 1, 14'h1, 4'hC, 32'h12341234, 1, 0, 1};
    vt[5] = '{1, 2, 16'h0002, 32'h0BAD, 0, 1, 14'h1, 4'hC, 32'h12341234, 1, 0, 1};
    vt[6] = '{0, 0, 16'h0000, 32'h0, 1, 0, 14'h0, 4'h0, 32'h0, 0, 0, 1};

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 2, 16'h0010, 32'h1, 1);
    chk("reset.req", 32'(sram_req), 0);
    chk("reset.fill", 32'(fill), 0);
    chk_model("reset");

    for (int i = 0; i < 7; i++) begin
      cyc(0, vt[i].w, vt[i].s, vt[i].a, vt[i].d, vt[i].g);
      chk($sformatf("vec%0d.req", i), 32'(sram_req), 32'(vt[i].req));
      chk($sformatf("vec%0d.addr", i), 32'(sram_addr), 32'(vt[i].addr));
      chk($sformatf("vec%0d.be", i), 32'(sram_be), 32'(vt[i].be));
      chk($sformatf("vec%0d.wdata", i), sram_wdata, vt[i].wd);
      chk($sformatf("vec%0d.fill", i), 32'(fill), 32'(vt[i].f));
      chk($sformatf("vec%0d.ovf", i), 32'(ovf_err), 32'(vt[i].ovf));
      chk($sformatf("vec%0d.align", i), 32'(align_err), 32'(vt[i].al));
    end

    // overflow: five beats with no grant, then drain in order
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 2, 16'(i * 4), 32'h1000 + 32'(i), 0);
    chk("ovf.fill", 32'(fill), 4);
    chk("ovf.flag", 32'(ovf_err), 1);
    chk_model("ovf");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.data", i), sram_wdata, 32'h1000 + 32'(i));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("drain.fill", 32'(fill), 0);
    chk("drain.ovf_sticky", 32'(ovf_err), 1);

    // push and pop together while full
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 16'(i * 4), 32'h2000 + 32'(i), 0);
    cyc(0, 1, 2, 16'h0040, 32'h0000AAAA, 1);
    chk("fullpp.fill", 32'(fill), 4);
    chk("fullpp.ovf", 32'(ovf_err), 0);
    chk("fullpp.head", sram_wdata, 32'h2001);
    chk_model("fullpp");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
    chk_model("fullpp.drained");

    // push and pop together with one entry
    cyc(0, 1, 0, 16'h0101, 32'h77, 0);
    cyc(0, 1, 2, 16'h0104, 32'hCAFEF00D, 1);
    chk("onepp.fill", 32'(fill), 1);
    chk("onepp.head", sram_wdata, 32'hCAFEF00D);
    chk_model("onepp");

    // reset with three pending entries and both flags set
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 2, 16'(i * 4), 32'h3000 + 32'(i), 0);
    cyc(0, 1, 1, 16'h0003, 32'h1, 1);
    chk("midrst.pre_fill", 32'(fill), 3);
    chk("midrst.pre_flags", 32'({ovf_err, align_err}), 32'h3);
    cyc(1, 1, 2, 16'h0008, 32'h9, 1);
    chk("midrst.fill", 32'(fill), 0);
    chk("midrst.req", 32'(sram_req), 0);
    chk("midrst.flags", 32'({ovf_err, align_err}), 0);
    chk_model("midrst");

    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 255));
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
          a, $urandom(), $urandom_range(0, 9) < (i % 200 < 100 ? 3 : 7));
      chk_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
